// File: rtl/j_pulse_pkg.sv
// Shared types and default field widths for the JERRY pulse generator
// and its measurement receiver.
package j_pulse_pkg;

    localparam int J_PERIOD_W = 8;
    localparam int J_WIDTH_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        MEAS = 2'd2
    } jp_state_e;

endpackage

// File: rtl/j_pulse_edge.sv
// Tick-qualified edge detector for the measured pulse stream.
// pin_q resets high so a line that is already high never looks like a rise.
module j_pulse_edge (
    input  logic sys_clk,
    input  logic reset,
    input  logic tick,
    input  logic pulse_in,
    output logic rise,
    output logic fall
);

    logic pin_q;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            pin_q <= 1'b1;
        end else if (tick) begin
            pin_q <= pulse_in;
        end
    end

    assign rise = tick & pulse_in & ~pin_q;
    assign fall = tick & ~pulse_in & pin_q;

endmodule

// File: rtl/j_pulse_meas.sv
// Pulse-train period / high-time measurement, results in the generator's
// count-minus-one divider encoding.
module j_pulse_meas
    import j_pulse_pkg::*;
#(
    parameter int PERIOD_W = J_PERIOD_W,
    parameter int WIDTH_W  = J_WIDTH_W
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                pulse_in,
    input  logic                arm,
    input  logic                stop,
    output logic [PERIOD_W-1:0] period,
    output logic [WIDTH_W-1:0]  width,
    output logic                valid,
    output logic                overflow,
    output logic                busy
);

    localparam logic [PERIOD_W-1:0] PMAX = '1;
    localparam logic [WIDTH_W-1:0]  WMAX = '1;

    jp_state_e           state, state_d;
    logic [PERIOD_W-1:0] pcnt, pcnt_d;
    logic [WIDTH_W-1:0]  wcnt, wcnt_d;
    logic                high_ph, high_d;
    logic [PERIOD_W-1:0] period_d;
    logic [WIDTH_W-1:0]  width_d;
    logic                valid_d;
    logic                ovf_d;
    logic                rise;
    logic                fall;

    j_pulse_edge u_edge (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .tick     (tick),
        .pulse_in (pulse_in),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            wcnt     <= '0;
            high_ph  <= 1'b0;
            period   <= '0;
            width    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            pcnt     <= pcnt_d;
            wcnt     <= wcnt_d;
            high_ph  <= high_d;
            period   <= period_d;
            width    <= width_d;
            valid    <= valid_d;
            overflow <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state;
        pcnt_d   = pcnt;
        wcnt_d   = wcnt;
        high_d   = high_ph;
        period_d = period;
        width_d  = width;
        valid_d  = 1'b0;
        ovf_d    = overflow;
        if (stop) begin
            state_d = IDLE;
            pcnt_d  = '0;
            wcnt_d  = '0;
            high_d  = 1'b0;
        end else if (arm) begin
            state_d = SYNC;
            ovf_d   = 1'b0;
            pcnt_d  = '0;
            wcnt_d  = '0;
            high_d  = 1'b0;
        end else if (tick) begin
            unique case (state)
                IDLE: begin
                    pcnt_d = '0;
                    wcnt_d = '0;
                end
                SYNC: begin
                    if (rise) begin
                        state_d = MEAS;
                        pcnt_d  = '0;
                        wcnt_d  = '0;
                        high_d  = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d = pcnt;
                        width_d  = wcnt;
                        valid_d  = 1'b1;
                        pcnt_d   = '0;
                        wcnt_d   = '0;
                        high_d   = 1'b1;
                    end else if (pcnt == PMAX) begin
                        // no edge within the counter range: resync
                        ovf_d   = 1'b1;
                        state_d = SYNC;
                        pcnt_d  = '0;
                        wcnt_d  = '0;
                        high_d  = 1'b0;
                    end else begin
                        pcnt_d = pcnt + 1'b1;
                        if (pulse_in && high_ph && wcnt != WMAX) begin
                            wcnt_d = wcnt + 1'b1;
                        end
                        // high phase only ever ends on the first low tick
                        if (fall) begin
                            high_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_j_pulse_meas.sv
// Directed bench for j_pulse_meas: period/width capture, tick gating,
// saturation, stop/arm priority and asynchronous reset.
module tb_j_pulse_meas;

    logic       sys_clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       pulse_in;
    logic       arm;
    logic       stop;
    logic [7:0] period;
    logic [6:0] width;
    logic       valid;
    logic       overflow;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt, first, last;

    j_pulse_meas dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .tick     (tick),
        .pulse_in (pulse_in),
        .arm      (arm),
        .stop     (stop),
        .period   (period),
        .width    (width),
        .valid    (valid),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge sys_clk);
        #1;
    endtask

    // pulse_in = (k % per) < high, tick on every tdiv-th cycle
    task automatic run_wave(input int per, input int high, input int n,
                            input int tdiv, output int vc,
                            output int vf, output int vl);
        vc = 0;
        vf = -1;
        vl = -1;
        arm  = 1'b0;
        stop = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick     = ((k % tdiv) == 0);
            pulse_in = ((k % per) < high);
            cyc();
            if (valid) begin
                vc++;
                if (vf < 0) vf = k;
                vl = k;
            end
        end
    endtask

    task automatic do_arm(input logic p);
        tick     = 1'b1;
        pulse_in = p;
        arm      = 1'b1;
        cyc();
        arm      = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        pulse_in = 1'b0;
        arm      = 1'b0;
        stop     = 1'b0;
        cyc();
        cyc();
        check_eq("rst_period", period, 0);
        check_eq("rst_width", width, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;

        // basic stream: period 10, high 3, tick every cycle
        tick = 1'b1;
        pulse_in = 1'b0;
        cyc();
        do_arm(1'b0);
        check_eq("arm_busy", busy, 1);
        run_wave(10, 3, 45, 1, cnt, first, last);
        check_eq("t1_count", cnt, 4);
        check_eq("t1_first", first, 10);
        check_eq("t1_last", last, 40);
        check_eq("t1_period", period, 9);
        check_eq("t1_width", width, 2);

        // tick every 2nd cycle: 20 cycles / 6 high -> 10 / 3 ticks
        do_arm(1'b0);
        run_wave(20, 6, 60, 2, cnt, first, last);
        check_eq("t2_count", cnt, 2);
        check_eq("t2_first", first, 20);
        check_eq("t2_period", period, 9);
        check_eq("t2_width", width, 2);

        // line high at arm: first real rise at 9, next at 16
        pulse_in = 1'b1;
        cyc();
        do_arm(1'b1);
        cnt = 0;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            pulse_in = (k < 5) ? 1'b1 : (k < 9) ? 1'b0 :
                       (k < 11) ? 1'b1 : (k < 16) ? 1'b0 : 1'b1;
            cyc();
            if (valid) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        check_eq("t3_count", cnt, 1);
        check_eq("t3_first", first, 16);
        check_eq("t3_period", period, 6);
        check_eq("t3_width", width, 1);

        // period saturation after one edge and 256 low ticks
        pulse_in = 1'b0;
        cyc();
        do_arm(1'b0);
        pulse_in = 1'b1;
        cyc();
        cnt = 0;
        pulse_in = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            cyc();
            if (valid) cnt++;
        end
        check_eq("t4_ovf_pre", overflow, 0);
        cyc();
        if (valid) cnt++;
        check_eq("t4_ovf", overflow, 1);
        check_eq("t4_busy", busy, 1);
        check_eq("t4_novalid", cnt, 0);
        check_eq("t4_period_held", period, 6);
        pulse_in = 1'b1;
        cyc();
        check_eq("t4_sync_novalid", valid, 0);
        check_eq("t4_ovf_sticky", overflow, 1);
        do_arm(1'b0);
        check_eq("t4_ovf_clr", overflow, 0);

        // long high time clips width
        pulse_in = 1'b0;
        cyc();
        do_arm(1'b0);
        run_wave(250, 200, 261, 1, cnt, first, last);
        check_eq("t5_count", cnt, 1);
        check_eq("t5_first", first, 250);
        check_eq("t5_period", period, 249);
        check_eq("t5_width", width, 127);

        // stop beats arm in the same cycle
        stop = 1'b1;
        arm  = 1'b1;
        cyc();
        stop = 1'b0;
        arm  = 1'b0;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_period", period, 249);
        check_eq("t6_width", width, 127);
        run_wave(10, 3, 30, 1, cnt, first, last);
        check_eq("t6_idle_count", cnt, 0);
        check_eq("t6_idle_busy", busy, 0);

        // fastest legal stream: period 2
        do_arm(1'b0);
        run_wave(2, 1, 20, 1, cnt, first, last);
        check_eq("t7_count", cnt, 9);
        check_eq("t7_first", first, 2);
        check_eq("t7_last", last, 18);
        check_eq("t7_period", period, 1);
        check_eq("t7_width", width, 0);

        // asynchronous reset while valid is high
        pulse_in = 1'b0;
        cyc();
        do_arm(1'b0);
        run_wave(10, 3, 21, 1, cnt, first, last);
        check_eq("t8_valid_pre", valid, 1);
        check_eq("t8_period_pre", period, 9);
        #3;
        reset = 1'b1;
        #1;
        check_eq("t8_rst_period", period, 0);
        check_eq("t8_rst_width", width, 0);
        check_eq("t8_rst_valid", valid, 0);
        check_eq("t8_rst_busy", busy, 0);
        cyc();
        reset = 1'b0;
        run_wave(10, 3, 30, 1, cnt, first, last);
        check_eq("t8_idle_count", cnt, 0);
        check_eq("t8_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/j_pulse_meas.md
# j_pulse_meas

Tick-qualified pulse-train measurement block, the receive side of the JERRY programmable pulse generator. It watches an incoming pulse stream and, on every rising edge, reports the preceding period and high time. Both values use the generator's divider encoding (count minus one), so a captured pair can be written straight back into a generator to reproduce the waveform. It sits beside the timer/serial clock logic and is used for external-clock rate detection and for loopback self-test of the generator.

## Interface
- PERIOD_W, 8, width of the period counter and result (generator "a" field)
- WIDTH_W, 7, width of the high-time counter and result (generator "b" field)

- sys_clk  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- tick  in  1  count enable; sampling and counting happen only on sys_clk edges with tick=1
- pulse_in  in  1  pulse stream, synchronous to sys_clk
- arm  in  1  one-cycle start/restart request
- stop  in  1  one-cycle abort; returns block to idle
- period  out  PERIOD_W  last captured period, ticks between rising edges minus 1
- width  out  WIDTH_W  last captured high time, high ticks minus 1
- valid  out  1  one-cycle strobe: period/width just updated
- overflow  out  1  sticky: period counter saturated with no edge
- busy  out  1  state is SYNC or MEAS

## Operation
- Edge detect: pin_q samples pulse_in on tick cycles in every state; it resets to 1. A rising edge is a tick cycle with pulse_in=1 and pin_q=0, so a line already high at arm does not produce an edge.
- States:
  - IDLE: counters held at 0.
  - SYNC: waiting for the first rising edge.
  - MEAS: measuring.
- Priority: reset > stop > arm > tick-driven activity.
- stop, any state: go to IDLE, clear pcnt/wcnt/high_ph and valid. period, width and overflow are held.
- arm, any state: go to SYNC, clear overflow, pcnt, wcnt and high_ph.
- SYNC, tick with edge: go to MEAS; pcnt=0, wcnt=0, high_ph=1. No valid.
- MEAS, tick with edge:
  - period<=pcnt, width<=wcnt, valid=1.
  - pcnt=0, wcnt=0, high_ph=1.
- MEAS, tick without edge:
  - pcnt+1.
  - If pulse_in=1 and high_ph, wcnt+1, saturating at 2^WIDTH_W-1.
  - If pulse_in=0, high_ph=0.
- Period saturation: a MEAS tick with pcnt=2^PERIOD_W-1 and no edge sets overflow=1 and goes to SYNC. No valid; outputs are held.
- Encoding: P ticks between edges gives period=P-1 (minimum 1, since a rising edge needs a prior low tick). W high ticks gives width=W-1, clipped at 127.
- Non-tick cycles: no state or counter change. valid still drops after one cycle.

## Timing
- Reset values: period=0, width=0, valid=0, overflow=0, busy=0, state IDLE, pin_q=1.
- period, width, valid and overflow are registered.
- Capture latency: when rising-edge tick cycle n is registered, period/width/valid are visible on cycle n+1. valid is high for exactly one sys_clk cycle.
- busy rises the cycle after arm and falls the cycle after stop.
- overflow rises the cycle after the saturating tick.
- Back-to-back: with tick=1 and period 2 (the fastest legal stream), valid asserts on every second cycle.
- Reset mid-measurement: outputs return to reset values immediately (asynchronous), and the block stays in IDLE until arm.

## Structure
- Package j_pulse_pkg: state enum (IDLE, SYNC, MEAS) and default widths PERIOD_W=8, WIDTH_W=7, shared with the generator.
- One sub-module: j_pulse_edge, containing pin_q and the tick-qualified rising/falling detect, with reset value 1.
- Top level holds the FSM, the two saturating counters, the output registers and the sticky overflow.

## Test plan
- tick=1; arm; pulse_in period 10, high 3 -> first valid after the second rising edge with period=9, width=2; then valid every 10 cycles.
- tick high every 2nd cycle; pulse_in period 20 cycles, high 6 cycles, edges aligned to tick -> period=9, width=2.
- pulse_in held high at arm, falls 5 cycles later, rises 4 cycles after that -> no valid; state reaches MEAS only at that rise.
- arm; one edge; pulse_in held low for 256 ticks -> overflow=1 on the cycle after the 256th tick, busy stays 1 (SYNC), no valid; next arm clears overflow.
- High time of 200 ticks within a 250-tick period -> width=127, period=249.
- stop asserted with arm in the same cycle in MEAS -> IDLE, busy=0, prior period/width held. Async reset mid-MEAS -> all outputs 0 immediately.
